// File: rtl/ahb_region_decoder_pkg.sv
// Shared encodings for the AHB-Lite region decoder tile: HTRANS and HRESP
// values, the default-slave state type and the HDRID stack-position codes.
package ahb_dec_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Default slave FSM encoding kept as plain constants for legacy netlists
  typedef logic [1:0] dslv_state_t;
  localparam dslv_state_t DSLV_IDLE = 2'b00;
  localparam dslv_state_t DSLV_ERR1 = 2'b01;
  localparam dslv_state_t DSLV_ERR2 = 2'b10;

  // Header stack ID is active-low one-hot
  localparam logic [3:0] HDRID_POS0 = 4'b1110;
  localparam logic [3:0] HDRID_POS1 = 4'b1101;
  localparam logic [3:0] HDRID_POS2 = 4'b1011;
  localparam logic [3:0] HDRID_POS3 = 4'b0111;

  typedef struct packed {
    logic       valid;
    logic [1:0] pos;
  } stack_pos_t;

  function automatic stack_pos_t hdrid_to_pos(input logic [3:0] hdrid);
    stack_pos_t r;
    r.valid = 1'b1;
    r.pos   = 2'd0;
    case (hdrid)
      HDRID_POS0: r.pos = 2'd0;
      HDRID_POS1: r.pos = 2'd1;
      HDRID_POS2: r.pos = 2'd2;
      HDRID_POS3: r.pos = 2'd3;
      default:    r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_region_decoder_if.sv
// Bus bundle between the tile's AHB-Lite master side and the region decoder.
// master: drives address phase, slave responses and ErrClr.
// slave:  the decoder, drives selects, muxed response and error capture.
interface ahb_region_decoder_if
  import ahb_dec_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned DATA_W     = 32
);

  logic [31:0]                   HADDR;
  logic [1:0]                    HTRANS;
  logic                          HREADYIn;
  logic [3:0]                    HDRID;
  logic [NUM_SLAVES-1:0]         HREADYOUTS;
  logic [2*NUM_SLAVES-1:0]       HRESPS;
  logic [DATA_W*NUM_SLAVES-1:0]  HRDATAS;

  logic                          HSELLOGICMODULE;
  logic [NUM_SLAVES-1:0]         HSEL;
  logic                          HSELDefault;
  logic                          HREADYOut;
  logic [1:0]                    HRESP;
  logic [DATA_W-1:0]             HRDATA;

  logic                          ErrClr;
  logic                          ErrValid;
  logic [31:0]                   ErrAddr;
  logic [7:0]                    ErrCount;

  modport master (
    output HADDR, HTRANS, HREADYIn, HDRID, HREADYOUTS, HRESPS, HRDATAS, ErrClr,
    input  HSELLOGICMODULE, HSEL, HSELDefault, HREADYOut, HRESP, HRDATA,
           ErrValid, ErrAddr, ErrCount
  );

  modport slave (
    input  HADDR, HTRANS, HREADYIn, HDRID, HREADYOUTS, HRESPS, HRDATAS, ErrClr,
    output HSELLOGICMODULE, HSEL, HSELDefault, HREADYOut, HRESP, HRDATA,
           ErrValid, ErrAddr, ErrCount
  );

endinterface

// File: rtl/ahb_region_decoder_default_slave.sv
// Built-in AHB-Lite default slave: two-cycle ERROR response for active
// transfers that hit the tile window but no region. Optional error capture
// is built only when AHB_DEC_ERR_CAPTURE_EN is defined.
module ahb_default_slave
  import ahb_dec_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_sel,
  input  logic        i_hready,
  input  logic        i_trans_active,
  input  logic [31:0] i_haddr,
  input  logic        i_err_clr,
  output logic        o_hready,
  output logic [1:0]  o_hresp,
  output logic        o_err_valid,
  output logic [31:0] o_err_addr,
  output logic [7:0]  o_err_count
);

  dslv_state_t r_state;
  dslv_state_t w_state_nxt;
  logic        w_start;

  assign w_start = i_hready & i_sel & i_trans_active;

  // Next state: ERR1 always finishes into ERR2 regardless of HREADYIn
  always_comb begin
    w_state_nxt = DSLV_IDLE;
    case (r_state)
      DSLV_IDLE: w_state_nxt = w_start ? DSLV_ERR1 : DSLV_IDLE;
      DSLV_ERR1: w_state_nxt = DSLV_ERR2;
      DSLV_ERR2: w_state_nxt = w_start ? DSLV_ERR1 : DSLV_IDLE;
      default:   w_state_nxt = DSLV_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= DSLV_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign o_hready = (r_state != DSLV_ERR1);
  assign o_hresp  = ((r_state == DSLV_ERR1) || (r_state == DSLV_ERR2)) ? HRESP_ERROR
                                                                       : HRESP_OKAY;

`ifdef AHB_DEC_ERR_CAPTURE_EN
  logic        r_err_valid;
  logic [31:0] r_err_addr;
  logic [7:0]  r_err_count;
  logic        w_err_entry;

  assign w_err_entry = w_start & (r_state != DSLV_ERR1);

  // Error capture: first address wins, a new error beats a same-cycle clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else if (w_err_entry) begin
      r_err_valid <= 1'b1;
      if (!r_err_valid || i_err_clr) r_err_addr <= i_haddr;
      if (i_err_clr)                 r_err_count <= 8'd1;
      else if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end else if (i_err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end
  end

  assign o_err_valid = r_err_valid;
  assign o_err_addr  = r_err_addr;
  assign o_err_count = r_err_count;
`else
  logic w_unused;
  assign w_unused    = ^{i_haddr, i_err_clr};
  assign o_err_valid = 1'b0;
  assign o_err_addr  = '0;
  assign o_err_count = '0;
`endif

endmodule

// File: rtl/ahb_region_decoder.sv
// AHB-Lite address decoder, default slave and response mux for a logic-module
// tile. Tile window is TILE_BASE + header stack position; inside it the lowest
// matching region wins, otherwise the default slave answers with ERROR.
// Error capture in the default slave is enabled by AHB_DEC_ERR_CAPTURE_EN.
module ahb_region_decoder
  import ahb_dec_pkg::*;
#(
  parameter int unsigned                 NUM_SLAVES  = 3,
  parameter int unsigned                 DATA_W      = 32,
  parameter logic [3:0]                  TILE_BASE   = 4'hC,
  parameter logic [28*NUM_SLAVES-1:0]    REGION_BASE = {28'h2000000, 28'h0000000, 28'h0000000},
  parameter logic [28*NUM_SLAVES-1:0]    REGION_MASK = {28'hFF00000, 28'hE000000, 28'hF000000}
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_region_decoder_if.slave   bus
);

  stack_pos_t            w_pos;
  logic [3:0]            w_tile_id;
  logic                  w_tile_hit;
  logic [NUM_SLAVES-1:0] w_match;
  logic                  w_found;
  logic [NUM_SLAVES-1:0] w_hsel;
  logic                  w_hsel_def;

  logic [NUM_SLAVES:0]   r_dsel;

  logic                  w_def_hready;
  logic [1:0]            w_def_hresp;

  logic                  w_hready;
  logic [1:0]            w_hresp;
  logic [DATA_W-1:0]     w_hrdata;

  assign w_pos      = hdrid_to_pos(bus.HDRID);
  assign w_tile_id  = TILE_BASE + {2'b00, w_pos.pos};
  assign w_tile_hit = w_pos.valid & (bus.HADDR[31:28] == w_tile_id) & HRESETn;

  // Region priority encode: lowest matching index wins
  always_comb begin
    w_match = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!w_found &&
          ((bus.HADDR[27:0] & REGION_MASK[28*i +: 28]) == REGION_BASE[28*i +: 28])) begin
        w_match[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign w_hsel     = w_match & {NUM_SLAVES{w_tile_hit}};
  assign w_hsel_def = w_tile_hit & ~w_found;

  assign bus.HSELLOGICMODULE = w_tile_hit;
  assign bus.HSEL            = w_hsel;
  assign bus.HSELDefault     = w_hsel_def;

  // Data-phase select, MSB is the default slave
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)          r_dsel <= '0;
    else if (bus.HREADYIn) r_dsel <= {w_hsel_def, w_hsel};
  end

  ahb_default_slave u_default_slave (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .i_sel          (w_hsel_def),
    .i_hready       (bus.HREADYIn),
    .i_trans_active (bus.HTRANS[1]),
    .i_haddr        (bus.HADDR),
    .i_err_clr      (bus.ErrClr),
    .o_hready       (w_def_hready),
    .o_hresp        (w_def_hresp),
    .o_err_valid    (bus.ErrValid),
    .o_err_addr     (bus.ErrAddr),
    .o_err_count    (bus.ErrCount)
  );

  // Response mux; no selection answers ready/OKAY with zero data
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    w_hrdata = '0;
    if (r_dsel[NUM_SLAVES]) begin
      w_hready = w_def_hready;
      w_hresp  = w_def_hresp;
    end else begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (r_dsel[i]) begin
          w_hready = bus.HREADYOUTS[i];
          w_hresp  = bus.HRESPS[2*i +: 2];
          w_hrdata = bus.HRDATAS[DATA_W*i +: DATA_W];
        end
      end
    end
  end

  assign bus.HREADYOut = w_hready;
  assign bus.HRESP     = w_hresp;
  assign bus.HRDATA    = w_hrdata;

endmodule

// File: tb/tb_ahb_region_decoder.sv
// Bench for ahb_region_decoder: vector table for decode/mux plus hand-written
// sequences for default-slave errors, wait states, error capture and reset.
module tb_ahb_region_decoder;
  import ahb_dec_pkg::*;

  logic HCLK;
  logic HRESETn;

  ahb_region_decoder_if #(.NUM_SLAVES(3), .DATA_W(32)) bus ();

  ahb_region_decoder #(.NUM_SLAVES(3), .DATA_W(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] a;
    logic [1:0]  t;
    logic        lm;
    logic [2:0]  sel;
    logic        def;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  localparam int NV = 14;
  vec_t tbl [NV];
  exp_t exp_q [$];
  int   n_vec;
  int   n_miss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic r, input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    e.rdy = r; e.resp = s; e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_err(input string nm, input logic v, input logic [31:0] a, input logic [7:0] c);
    logic       ev;
    logic [31:0] ea;
    logic [7:0]  ec;
`ifdef AHB_DEC_ERR_CAPTURE_EN
    ev = v; ea = a; ec = c;
`else
    ev = 1'b0; ea = '0; ec = '0;
    if (v || (a != 0) || (c != 0)) ev = 1'b0;
`endif
    chk({nm, "_errvalid"}, 32'(bus.ErrValid), 32'(ev));
    chk({nm, "_erraddr"},  bus.ErrAddr,       ea);
    chk({nm, "_errcount"}, 32'(bus.ErrCount), 32'(ec));
  endtask

  // One bus cycle: drive, check selects and the scoreboard head at negedge
  task automatic cycle(input logic [3:0] id, input logic [31:0] a, input logic [1:0] t,
                       input logic rin, input logic clr, input logic chk_sel,
                       input logic elm, input logic [2:0] esel, input logic edef,
                       input string nm);
    exp_t e;
    bus.HDRID = id; bus.HADDR = a; bus.HTRANS = t;
    bus.HREADYIn = rin; bus.ErrClr = clr;
    @(negedge HCLK);
    if (chk_sel) begin
      chk({nm, "_lm"},   32'(bus.HSELLOGICMODULE), 32'(elm));
      chk({nm, "_hsel"}, 32'(bus.HSEL),            32'(esel));
      chk({nm, "_hdef"}, 32'(bus.HSELDefault),     32'(edef));
    end
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s_sb: scoreboard empty, got no entry expected one", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_hready"}, 32'(bus.HREADYOut), 32'(e.rdy));
      chk({nm, "_hresp"},  32'(bus.HRESP),     32'(e.resp));
      chk({nm, "_hrdata"}, bus.HRDATA,         e.rdata);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic run_default_err(input logic [31:0] a, input logic clr, input string nm);
    cycle(HDRID_POS0, a, HTRANS_NONSEQ, 1'b1, clr, 1'b1, 1'b1, 3'b000, 1'b1, {nm, "_issue"});
    push_exp(1'b0, HRESP_ERROR, 32'h0);
    push_exp(1'b1, HRESP_ERROR, 32'h0);
    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, {nm, "_err1"});
    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, {nm, "_err2"});
    push_exp(1'b1, HRESP_OKAY, 32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_miss = 0;
    //          id          addr          trans          lm    sel     def   rdy   resp         rdata
    tbl[0]  = '{HDRID_POS1, 32'hD2000010, HTRANS_NONSEQ, 1'b1, 3'b100, 1'b0, 1'b1, HRESP_OKAY,  32'hCCCC2222};
    tbl[1]  = '{HDRID_POS0, 32'hC0000040, HTRANS_NONSEQ, 1'b1, 3'b001, 1'b0, 1'b1, HRESP_OKAY,  32'hAAAA0000};
    tbl[2]  = '{HDRID_POS0, 32'hC1234568, HTRANS_SEQ,    1'b1, 3'b010, 1'b0, 1'b1, HRESP_ERROR, 32'hBBBB1111};
    tbl[3]  = '{HDRID_POS0, 32'hC4000000, HTRANS_IDLE,   1'b1, 3'b000, 1'b1, 1'b1, HRESP_OKAY,  32'h0};
    tbl[4]  = '{HDRID_POS0, 32'hC4000000, HTRANS_BUSY,   1'b1, 3'b000, 1'b1, 1'b1, HRESP_OKAY,  32'h0};
    tbl[5]  = '{4'b1111,    32'hC0000000, HTRANS_NONSEQ, 1'b0, 3'b000, 1'b0, 1'b1, HRESP_OKAY,  32'h0};
    tbl[6]  = '{HDRID_POS3, 32'hC0000000, HTRANS_NONSEQ, 1'b0, 3'b000, 1'b0, 1'b1, HRESP_OKAY,  32'h0};
    tbl[7]  = '{HDRID_POS3, 32'hF2000000, HTRANS_NONSEQ, 1'b1, 3'b100, 1'b0, 1'b1, HRESP_OKAY,  32'hCCCC2222};
    tbl[8]  = '{HDRID_POS2, 32'hE0000000, HTRANS_NONSEQ, 1'b1, 3'b001, 1'b0, 1'b1, HRESP_OKAY,  32'hAAAA0000};
    tbl[9]  = '{HDRID_POS2, 32'hD0000000, HTRANS_NONSEQ, 1'b0, 3'b000, 1'b0, 1'b1, HRESP_OKAY,  32'h0};
    tbl[10] = '{4'b0000,    32'hC0000000, HTRANS_NONSEQ, 1'b0, 3'b000, 1'b0, 1'b1, HRESP_OKAY,  32'h0};
    tbl[11] = '{HDRID_POS1, 32'hD2100000, HTRANS_IDLE,   1'b1, 3'b000, 1'b1, 1'b1, HRESP_OKAY,  32'h0};
    tbl[12] = '{HDRID_POS1, 32'hD1FFFFFF, HTRANS_NONSEQ, 1'b1, 3'b010, 1'b0, 1'b1, HRESP_ERROR, 32'hBBBB1111};
    tbl[13] = '{HDRID_POS1, 32'hD0FFFFFF, HTRANS_NONSEQ, 1'b1, 3'b001, 1'b0, 1'b1, HRESP_OKAY,  32'hAAAA0000};

    bus.HRDATAS    = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
    bus.HRESPS     = {HRESP_OKAY, HRESP_ERROR, HRESP_OKAY};
    bus.HREADYOUTS = 3'b111;
    bus.HDRID = 4'b1111; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    bus.HREADYIn = 1'b1; bus.ErrClr = 1'b0;

    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hready", 32'(bus.HREADYOut), 32'd1);
    chk("rst_hresp",  32'(bus.HRESP),     32'(HRESP_OKAY));
    chk("rst_hrdata", bus.HRDATA,         32'h0);
    chk_err("rst", 1'b0, 32'h0, 8'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    push_exp(1'b1, HRESP_OKAY, 32'h0);

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].id, tbl[i].a, tbl[i].t, 1'b1, 1'b0, 1'b1,
            tbl[i].lm, tbl[i].sel, tbl[i].def, $sformatf("vec%0d", i));
      push_exp(tbl[i].rdy, tbl[i].resp, tbl[i].rdata);
    end
    // IDLE/BUSY to the default slave must not capture anything
    chk_err("idle_busy", 1'b0, 32'h0, 8'd0);

    run_default_err(32'hC4000000, 1'b0, "deferr");
    chk_err("deferr", 1'b1, 32'hC4000000, 8'd1);

    // Back-to-back default NONSEQ: ERR1 ERR2 ERR1 ERR2 with no IDLE gap
    cycle(HDRID_POS0, 32'hC4000000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "b2b_a");
    push_exp(1'b0, HRESP_ERROR, 32'h0);
    push_exp(1'b1, HRESP_ERROR, 32'h0);
    cycle(HDRID_POS0, 32'hCA000000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "b2b_err1a");
    cycle(HDRID_POS0, 32'hCA000000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "b2b_err2a");
    push_exp(1'b0, HRESP_ERROR, 32'h0);
    push_exp(1'b1, HRESP_ERROR, 32'h0);
    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "b2b_err1b");
    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "b2b_err2b");
    push_exp(1'b1, HRESP_OKAY, 32'h0);
    chk_err("b2b", 1'b1, 32'hC4000000, 8'd3);

    // Clear coinciding with a new error: the new error wins
    run_default_err(32'hC8000000, 1'b1, "clrerr");
    chk_err("clrerr", 1'b1, 32'hC8000000, 8'd1);

    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, "clr");
    push_exp(1'b1, HRESP_OKAY, 32'h0);
    chk_err("clr", 1'b0, 32'h0, 8'd0);

    // Slave 0 wait states while the next address targets slave 1
    cycle(HDRID_POS0, 32'hC0000100, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, "ws_issue");
    push_exp(1'b0, HRESP_OKAY, 32'hAAAA0000);
    push_exp(1'b0, HRESP_OKAY, 32'hAAAA0000);
    push_exp(1'b0, HRESP_OKAY, 32'hAAAA0000);
    push_exp(1'b1, HRESP_OKAY, 32'hAAAA0000);
    bus.HREADYOUTS = 3'b110;
    for (int w = 0; w < 3; w++)
      cycle(HDRID_POS0, 32'hC1000000, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0,
            $sformatf("ws_wait%0d", w));
    bus.HREADYOUTS = 3'b111;
    cycle(HDRID_POS0, 32'hC1000000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, "ws_done");
    push_exp(1'b1, HRESP_ERROR, 32'hBBBB1111);

    // Reset during ERR1, then a full error again
    cycle(HDRID_POS0, 32'hC4000000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, "rst_issue");
    chk("rst_pre_hready", 32'(bus.HREADYOut), 32'd0);
    chk("rst_pre_hresp",  32'(bus.HRESP),     32'(HRESP_ERROR));
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_hready", 32'(bus.HREADYOut),       32'd1);
    chk("rst_mid_hresp",  32'(bus.HRESP),           32'(HRESP_OKAY));
    chk("rst_mid_hrdata", bus.HRDATA,               32'h0);
    chk("rst_mid_lm",     32'(bus.HSELLOGICMODULE), 32'd0);
    chk("rst_mid_hdef",   32'(bus.HSELDefault),     32'd0);
    chk("rst_mid_hsel",   32'(bus.HSEL),            32'd0);
    chk_err("rst_mid", 1'b0, 32'h0, 8'd0);
    bus.HDRID = 4'b1111; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HREADYIn = 1'b1;
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    push_exp(1'b1, HRESP_OKAY, 32'h0);
    run_default_err(32'hC4000000, 1'b0, "post_rst");
    chk_err("post_rst", 1'b1, 32'hC4000000, 8'd1);

    cycle(4'b1111, 32'h0, HTRANS_IDLE, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, "drain");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
